// File: rtl/mult_operand_feeder.sv
// Purpose : queues operand pairs and feeds them one at a time to a sequential
//           multiplier, returning each product (or a timeout marker) with a tag.
// Latency : push -> mul_start two edges later when idle; mul_ready -> res_valid
//           next cycle; result accept -> next mul_start next cycle.
// Backpr. : in_ready drops while the operand FIFO is full; a held result stalls
//           further issue until res_ready accepts it.
//
// Ports:
//   clk_in, rst_in               clock (rising edge), async active-high reset
//   in_valid/in_ready/in_x/in_y  operand pair input handshake
//   mul_x/mul_y/mul_start        registered operands and one-cycle start pulse
//   mul_ready/mul_product        multiplier completion and product
//   res_valid/res_ready          result handshake
//   res_data/res_tag/res_err     product (0 on timeout), issue tag, timeout flag
//   err_sticky                   any timeout since reset
module mult_operand_feeder #(
  parameter int OPERAND_W = 4,
  parameter int PROD_W    = 8,
  parameter int DEPTH     = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OPERAND_W-1:0] in_x,
  input  logic [OPERAND_W-1:0] in_y,
  output logic [OPERAND_W-1:0] mul_x,
  output logic [OPERAND_W-1:0] mul_y,
  output logic                 mul_start,
  input  logic                 mul_ready,
  input  logic [PROD_W-1:0]    mul_product,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [PROD_W-1:0]    res_data,
  output logic [1:0]           res_tag,
  output logic                 res_err,
  output logic                 err_sticky
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

  state_t state_q, state_d;

  logic [2*OPERAND_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic [1:0]             tag_q, tag_d;
  logic [1:0]             res_tag_q, res_tag_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [OPERAND_W-1:0]   mul_x_q, mul_x_d;
  logic [OPERAND_W-1:0]   mul_y_q, mul_y_d;
  logic [PROD_W-1:0]      res_data_q, res_data_d;
  logic                   res_err_q, res_err_d;
  logic                   err_sticky_q, err_sticky_d;

  logic                   push;
  logic                   pop;
  logic                   fifo_nonempty;
  logic                   timer_expired;
  logic [OPERAND_W-1:0]   head_x;
  logic [OPERAND_W-1:0]   head_y;

  assign fifo_nonempty = (count_q != '0);
  assign push          = in_valid && in_ready;
  assign pop           = (state_q == S_ISSUE);
  assign timer_expired = (timer_q == TW'(TIMEOUT - 1));
  assign {head_x, head_y} = mem_q[rd_ptr_q];

  // State register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Leaving HOLD looks at the count before any push that
  // lands on the same edge, so a just-arriving pair waits one IDLE cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (fifo_nonempty) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (mul_ready || timer_expired) state_d = S_HOLD;
      S_HOLD:  if (res_ready) state_d = fifo_nonempty ? S_ISSUE : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    mul_start  = (state_q == S_ISSUE);
    res_valid  = (state_q == S_HOLD);
    in_ready   = (count_q != CW'(DEPTH));
    mul_x      = mul_x_q;
    mul_y      = mul_y_q;
    res_data   = res_data_q;
    res_tag    = res_tag_q;
    res_err    = res_err_q;
    err_sticky = err_sticky_q;
  end

  // Datapath next-state
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    tag_d        = tag_q;
    res_tag_d    = res_tag_q;
    timer_d      = timer_q;
    mul_x_d      = mul_x_q;
    mul_y_d      = mul_y_q;
    res_data_d   = res_data_q;
    res_err_d    = res_err_q;
    err_sticky_d = err_sticky_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Operands are captured on the way into ISSUE so they are already valid
    // alongside the start pulse; the head is popped at the end of ISSUE.
    if (state_d == S_ISSUE) begin
      mul_x_d = head_x;
      mul_y_d = head_y;
    end

    if (state_q == S_ISSUE) begin
      res_tag_d = tag_q;
      tag_d     = tag_q + 2'd1;
      timer_d   = '0;
    end

    // A product arriving on the final timer cycle takes priority over timeout.
    if (state_q == S_WAIT) begin
      if (mul_ready) begin
        res_data_d = mul_product;
        res_err_d  = 1'b0;
      end else if (timer_expired) begin
        res_data_d   = '0;
        res_err_d    = 1'b1;
        err_sticky_d = 1'b1;
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      tag_q        <= '0;
      res_tag_q    <= '0;
      timer_q      <= '0;
      mul_x_q      <= '0;
      mul_y_q      <= '0;
      res_data_q   <= '0;
      res_err_q    <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      tag_q        <= tag_d;
      res_tag_q    <= res_tag_d;
      timer_q      <= timer_d;
      mul_x_q      <= mul_x_d;
      mul_y_q      <= mul_y_d;
      res_data_q   <= res_data_d;
      res_err_q    <= res_err_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  // Storage needs no reset: entries are only read once the count covers them.
  always_ff @(posedge clk_in) begin
    if (push) mem_q[wr_ptr_q] <= {in_x, in_y};
  end

endmodule

// File: tb/tb_mult_operand_feeder.sv
module tb_mult_operand_feeder;

  logic       clk = 1'b0;
  logic       rst_in;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_x, in_y;
  logic [3:0] mul_x, mul_y;
  logic       mul_start;
  logic       mul_ready = 1'b0;
  logic [7:0] mul_product = 8'd0;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic [1:0] res_tag;
  logic       res_err;
  logic       err_sticky;

  int vectors     = 0;
  int miscompares = 0;

  // Multiplier model state
  int         model_delay = 1;
  bit         model_never = 1'b0;
  bit         busy        = 1'b0;
  int         cd          = 0;
  logic [3:0] mx = 4'd0, my = 4'd0;

  always #5 clk = ~clk;

  mult_operand_feeder dut (
    .clk_in      (clk),
    .rst_in      (rst_in),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_x        (in_x),
    .in_y        (in_y),
    .mul_x       (mul_x),
    .mul_y       (mul_y),
    .mul_start   (mul_start),
    .mul_ready   (mul_ready),
    .mul_product (mul_product),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_tag     (res_tag),
    .res_err     (res_err),
    .err_sticky  (err_sticky)
  );

  // Sequential multiplier model: sees start at a negedge, raises mul_ready
  // for one cycle in the model_delay-th cycle after the start cycle.
  always @(negedge clk) begin
    mul_ready = 1'b0;
    if (mul_start && !model_never) begin
      mx   = mul_x;
      my   = mul_y;
      cd   = model_delay;
      busy = 1'b1;
    end else if (busy) begin
      if (cd <= 1) begin
        mul_ready   = 1'b1;
        mul_product = {4'd0, mx} * {4'd0, my};
        busy        = 1'b0;
      end else begin
        cd = cd - 1;
      end
    end
  end

  task automatic do_reset();
    rst_in = 1'b1; in_valid = 1'b0; res_ready = 1'b0;
    busy = 1'b0; model_never = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_in = 1'b0;
    @(negedge clk);
  endtask

  task automatic push(input logic [3:0] x, input logic [3:0] y);
    in_valid = 1'b1; in_x = x; in_y = y;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_res(input int max, output int n);
    n = 0;
    while (!res_valid && n < max) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic accept();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    @(negedge clk); @(negedge clk);
    vectors++;
    if ({mul_start, mul_x, mul_y, res_valid, res_data, res_err, err_sticky, res_tag} !== 23'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h expected 0",
               {mul_start, mul_x, mul_y, res_valid, res_data, res_err, err_sticky, res_tag});
    end
    rst_in = 1'b0;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    vectors++;
    if (dut.count_q !== 3'd0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", dut.count_q); end
  endtask

  task automatic test_single_op();
    int n;
    do_reset(); model_delay = 6;
    push(4'd3, 4'd5);
    vectors++;
    if (mul_start !== 1'b0) begin miscompares++; $display("FAIL single_start_early: got %b expected 0", mul_start); end
    @(negedge clk);
    vectors++;
    if ({mul_start, mul_x, mul_y} !== {1'b1, 4'd3, 4'd5}) begin
      miscompares++;
      $display("FAIL single_issue: got start=%b x=%0d y=%0d expected start=1 x=3 y=5", mul_start, mul_x, mul_y);
    end
    @(negedge clk);
    vectors++;
    if ({mul_start, mul_x, mul_y} !== {1'b0, 4'd3, 4'd5}) begin
      miscompares++;
      $display("FAIL single_pulse: got start=%b x=%0d y=%0d expected start=0 x=3 y=5", mul_start, mul_x, mul_y);
    end
    wait_res(40, n);
    vectors++;
    if (n !== 6) begin miscompares++; $display("FAIL single_latency: got %0d expected 6", n); end
    vectors++;
    if ({res_data, res_tag, res_err} !== {8'd15, 2'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL single_result: got data=%0d tag=%0d err=%b expected 15 0 0", res_data, res_tag, res_err);
    end
    accept();
    vectors++;
    if ({res_valid, mul_start} !== 2'b00) begin
      miscompares++;
      $display("FAIL single_after_accept: got valid=%b start=%b expected 0 0", res_valid, mul_start);
    end
  endtask

  task automatic test_fill();
    int  got;
    bit  expect_start;
    do_reset(); model_delay = 1;
    for (int i = 1; i <= 5; i++) push(4'(i), 4'(i));
    vectors++;
    if ({in_ready, dut.count_q, res_valid, res_data} !== {1'b0, 3'd4, 1'b1, 8'd1}) begin
      miscompares++;
      $display("FAIL fill_full: got in_ready=%b count=%0d valid=%b data=%0d expected 0 4 1 1",
               in_ready, dut.count_q, res_valid, res_data);
    end
    push(4'd9, 4'd9);  // offered while full: must be dropped
    vectors++;
    if (dut.count_q !== 3'd4) begin miscompares++; $display("FAIL fill_no_overflow: got %0d expected 4", dut.count_q); end
    got = 0; expect_start = 1'b0;
    res_ready = 1'b1;
    for (int c = 0; c < 200 && got < 5; c++) begin
      if (expect_start) begin
        vectors++;
        if (mul_start !== 1'b1) begin miscompares++; $display("FAIL fill_b2b_start%0d: got %b expected 1", got, mul_start); end
        expect_start = 1'b0;
      end
      if (res_valid) begin
        vectors++;
        if ({res_data, res_tag, res_err} !== {8'((got + 1) * (got + 1)), 2'(got), 1'b0}) begin
          miscompares++;
          $display("FAIL fill_result%0d: got data=%0d tag=%0d err=%b expected %0d %0d 0",
                   got, res_data, res_tag, res_err, (got + 1) * (got + 1), got % 4);
        end
        got++;
        expect_start = (got < 5);
      end
      @(negedge clk);
    end
    res_ready = 1'b0;
    vectors++;
    if (got !== 5) begin miscompares++; $display("FAIL fill_count_results: got %0d expected 5", got); end
    vectors++;
    if ({dut.count_q, mul_start} !== {3'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL fill_drained: got count=%0d start=%b expected 0 0", dut.count_q, mul_start);
    end
  endtask

  task automatic test_timeout();
    int n;
    do_reset(); model_never = 1'b1;
    push(4'd7, 4'd2);
    @(negedge clk);
    wait_res(60, n);
    vectors++;
    if (n !== 17) begin miscompares++; $display("FAIL timeout_latency: got %0d expected 17", n); end
    vectors++;
    if ({res_data, res_tag, res_err, err_sticky} !== {8'd0, 2'd0, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL timeout_result: got data=%0d tag=%0d err=%b sticky=%b expected 0 0 1 1",
               res_data, res_tag, res_err, err_sticky);
    end
    accept();
    model_never = 1'b0; model_delay = 3;
    push(4'd2, 4'd2);
    wait_res(40, n);
    vectors++;
    if ({res_valid, res_data, res_tag, res_err, err_sticky} !== {1'b1, 8'd4, 2'd1, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL timeout_next_op: got valid=%b data=%0d tag=%0d err=%b sticky=%b expected 1 4 1 0 1",
               res_valid, res_data, res_tag, res_err, err_sticky);
    end
    accept();
  endtask

  task automatic test_timeout_boundary();
    int n;
    do_reset(); model_delay = 16;
    push(4'd7, 4'd2);
    @(negedge clk);
    wait_res(60, n);
    vectors++;
    if (n !== 17) begin miscompares++; $display("FAIL boundary_latency: got %0d expected 17", n); end
    vectors++;
    if ({res_data, res_err, err_sticky} !== {8'd14, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL boundary_result: got data=%0d err=%b sticky=%b expected 14 0 0", res_data, res_err, err_sticky);
    end
    accept();
  endtask

  task automatic test_push_pop();
    int         n;
    int         got;
    logic [7:0] exp_d [3];
    exp_d[0] = 8'd12; exp_d[1] = 8'd30; exp_d[2] = 8'd56;
    do_reset(); model_delay = 1;
    push(4'd1, 4'd2); push(4'd3, 4'd4); push(4'd5, 4'd6);
    wait_res(20, n);
    vectors++;
    if ({res_valid, res_data, res_tag, dut.count_q} !== {1'b1, 8'd2, 2'd0, 3'd2}) begin
      miscompares++;
      $display("FAIL pp_first: got valid=%b data=%0d tag=%0d count=%0d expected 1 2 0 2",
               res_valid, res_data, res_tag, dut.count_q);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    vectors++;
    if ({mul_start, mul_x, mul_y} !== {1'b1, 4'd3, 4'd4}) begin
      miscompares++;
      $display("FAIL pp_issue: got start=%b x=%0d y=%0d expected 1 3 4", mul_start, mul_x, mul_y);
    end
    push(4'd7, 4'd8);  // lands on the same edge as the pop
    vectors++;
    if (dut.count_q !== 3'd2) begin miscompares++; $display("FAIL pp_count: got %0d expected 2", dut.count_q); end
    got = 0;
    res_ready = 1'b1;
    for (int c = 0; c < 100 && got < 3; c++) begin
      if (res_valid) begin
        vectors++;
        if ({res_data, res_tag} !== {exp_d[got], 2'(got + 1)}) begin
          miscompares++;
          $display("FAIL pp_order%0d: got data=%0d tag=%0d expected %0d %0d", got, res_data, res_tag, exp_d[got], got + 1);
        end
        got++;
      end
      @(negedge clk);
    end
    res_ready = 1'b0;
    vectors++;
    if (got !== 3) begin miscompares++; $display("FAIL pp_count_results: got %0d expected 3", got); end
  endtask

  task automatic test_reset_mid_wait();
    int n;
    bit seen_valid;
    bit seen_start;
    do_reset(); model_delay = 8;
    push(4'd2, 4'd3); push(4'd4, 4'd5); push(4'd6, 4'd7);
    @(negedge clk);
    vectors++;
    if (dut.count_q !== 3'd2) begin miscompares++; $display("FAIL rmw_queued: got %0d expected 2", dut.count_q); end
    rst_in = 1'b1;
    @(negedge clk);
    rst_in = 1'b0;
    seen_valid = 1'b0; seen_start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      seen_valid |= res_valid;
      seen_start |= mul_start;
    end
    vectors++;
    if ({seen_valid, seen_start, dut.count_q, res_tag, in_ready} !== {1'b0, 1'b0, 3'd0, 2'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL rmw_discard: got valid=%b start=%b count=%0d tag=%0d in_ready=%b expected 0 0 0 0 1",
               seen_valid, seen_start, dut.count_q, res_tag, in_ready);
    end
    model_delay = 1;
    push(4'd1, 4'd1);
    wait_res(20, n);
    vectors++;
    if ({res_valid, res_data, res_tag} !== {1'b1, 8'd1, 2'd0}) begin
      miscompares++;
      $display("FAIL rmw_after: got valid=%b data=%0d tag=%0d expected 1 1 0", res_valid, res_data, res_tag);
    end
    accept();
  endtask

  initial begin
    rst_in = 1'b1; in_valid = 1'b0; in_x = 4'd0; in_y = 4'd0; res_ready = 1'b0;
    test_reset();
    test_single_op();
    test_fill();
    test_timeout();
    test_timeout_boundary();
    test_push_pop();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mult_operand_feeder.md
Name: mult_operand_feeder

Overview:
- Upstream feeder for the sequential 4-bit multiplier.
- Accepts operand pairs on a valid/ready input.
- Buffers them in a small FIFO and issues them one at a time to the multiplier's start/ready handshake.
- Returns each tagged product on a valid/ready result port, with a watchdog timeout so a stalled multiplier cannot hang the pipeline.

Parameters:
- OPERAND_W, 4, width of each operand.
- PROD_W, 8, width of product returned by multiplier and forwarded on result port.
- DEPTH, 4, operand FIFO entries; power of two, ≥2.
- TIMEOUT, 16, max cycles spent in WAIT before abandoning an operation; ≥2.

Ports:
- clk_in  input  1  clock, all state on rising edge.
- rst_in  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operand pair offered.
- in_ready  output  1  FIFO can accept (not full).
- in_x  input  OPERAND_W  multiplicand.
- in_y  input  OPERAND_W  multiplier.
- mul_x  output  OPERAND_W  operand x to multiplier, registered.
- mul_y  output  OPERAND_W  operand y to multiplier, registered.
- mul_start  output  1  one-cycle start pulse to multiplier.
- mul_ready  input  1  multiplier done; mul_product valid this cycle.
- mul_product  input  PROD_W  product from multiplier.
- res_valid  output  1  result held for consumer.
- res_ready  input  1  consumer accepts result.
- res_data  output  PROD_W  product; 0 on timeout.
- res_tag  output  2  issue sequence number, wraps 3→0.
- res_err  output  1  this result is a timeout.
- err_sticky  output  1  set on any timeout, cleared only by reset.

Behaviour:
- Reset (async, rst_in=1): FIFO empty, pointers/count 0, state IDLE, tag 0, timer 0. in_ready=1 after reset releases. mul_start=0, mul_x=mul_y=0, res_valid=0, res_data=0, res_err=0, err_sticky=0.
- Reset mid-operation: discards all queued and in-flight work; a later mul_ready is ignored because the state is IDLE.
- FIFO:
  - Push when in_valid&&in_ready; in_ready = (count!=DEPTH), no write bypass when full.
  - Pop occurs only in ISSUE.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo DEPTH.
  - Data is ordered strictly FIFO.
- States: IDLE, ISSUE, WAIT, HOLD.
  - IDLE: if count!=0 → ISSUE, else stay.
  - ISSUE (exactly 1 cycle):
    - mul_start=1; mul_x/mul_y registered from FIFO head; pop.
    - Current tag latched; tag counter increments.
    - Timer cleared; → WAIT.
  - WAIT:
    - mul_start=0; mul_x/mul_y held stable.
    - If mul_ready: res_data<=mul_product, res_err<=0 → HOLD.
    - Else if timer==TIMEOUT-1: res_data<=0, res_err<=1, err_sticky<=1 → HOLD.
    - Else timer++.
    - mul_ready wins if it arrives on the timeout cycle.
  - HOLD:
    - res_valid=1; res_data/res_tag/res_err stable until accepted.
    - On res_ready: → ISSUE if count!=0 (count sampled this cycle, before any concurrent push lands), else → IDLE.
- Latency:
  - Push at edge t → mul_start high in cycle t+2 when idle.
  - Multiplier done → res_valid the next cycle.
  - Back-to-back issue when the FIFO is non-empty: result accept → next mul_start 1 cycle later.
- mul_ready is ignored in IDLE, ISSUE and HOLD.
- Only one operation is in flight; no new start is issued until the result is accepted.
- Width: the product is passed through unmodified; no arithmetic in this block.

Test Plan:
- Reset then single op: push (3,5); multiplier model returns 15 after 6 cycles. Expect mul_start one cycle with mul_x=3, mul_y=5, then res_valid with res_data=15, res_tag=0, res_err=0.
- Fill/full: with res_ready=0, push 5 pairs (1,1)..(5,5), DEPTH=4. Expect the first pair issued and held in HOLD, 4 pairs queued, in_ready=0 at count 4. Release res_ready and expect results 1,4,9,16,25 with tags 0,1,2,3,0 in order.
- Timeout: push (7,2); model never asserts mul_ready. Expect res_valid after TIMEOUT cycles in WAIT with res_data=0, res_err=1, err_sticky=1. A following op (2,2) returns 4 with res_err=0 and err_sticky still 1.
- Timeout boundary: mul_ready on the cycle timer==TIMEOUT-1 with product 14. Expect res_data=14, res_err=0, err_sticky=0.
- Simultaneous push/pop: count=2, push in the ISSUE cycle. Expect count stays 2 and order is preserved.
- Reset mid-WAIT: assert rst_in during WAIT with 2 queued, then model asserts mul_ready after release. Expect no res_valid, count 0, tag 0.
